// File: rtl/tictactoe_move_ctrl_if.sv
// Move request / checker / board-state bundle between player logic, the move
// checker, the display/win logic and the move controller.
interface tictactoe_move_ctrl_if;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;
  logic       illegal_move;
  logic [8:0] X_en;
  logic [8:0] O_en;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       turn;
  logic       move_ack;
  logic       move_nack;
  logic       timeout;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output new_game, move_valid, move_idx, illegal_move,
    input  move_ready, X_en, O_en,
           pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
           turn, move_ack, move_nack, timeout, game_over, winner
  );

  modport slave (
    input  new_game, move_valid, move_idx, illegal_move,
    output move_ready, X_en, O_en,
           pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
           turn, move_ack, move_nack, timeout, game_over, winner
  );
endinterface

// File: rtl/tictactoe_move_ctrl.sv
// Tic-tac-toe move writer: owns the board and turn, drives one-hot move enables,
// commits legal moves, detects win/draw and forfeits turns on timeout.
module tictactoe_line_chk (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] mark,
  output logic       win
);
  assign win = (a == mark) && (b == mark) && (c == mark);
endmodule

module tictactoe_move_ctrl #(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TO_W           = 29,
  parameter bit O_FIRST        = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  tictactoe_move_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_WAIT, S_CHECK, S_EVAL, S_DONE} state_t;

  localparam logic [1:0]      MARK_X  = 2'b01;
  localparam logic [1:0]      MARK_O  = 2'b10;
  localparam logic [1:0]      DRAW    = 2'b11;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  // rows, columns, diagonals as square indices
  localparam int LINE_SQ [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
                                    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
                                    '{0, 4, 8}, '{2, 4, 6}};

  state_t          state;
  logic [8:0][1:0] board;
  logic [3:0]      idx_r;
  logic [TO_W-1:0] to_cnt;
  logic            turn_r;
  logic [8:0]      x_en_r, o_en_r;
  logic            ack_r, nack_r, to_r, over_r;
  logic [1:0]      winner_r;

  logic [1:0]      mover;
  logic [8:0]      idx_oh;
  logic [7:0]      line_win;
  logic            board_full;

  assign mover  = turn_r ? MARK_O : MARK_X;
  assign idx_oh = 9'b1 << bus.move_idx;

  for (genvar g = 0; g < 8; g++) begin : g_line
    tictactoe_line_chk u_line (
      .a    (board[LINE_SQ[g][0]]),
      .b    (board[LINE_SQ[g][1]]),
      .c    (board[LINE_SQ[g][2]]),
      .mark (mover),
      .win  (line_win[g])
    );
  end

  always_comb begin
    board_full = 1'b1;
    for (int k = 0; k < 9; k++)
      if (board[k] == 2'b00) board_full = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT;
      board    <= '0;
      idx_r    <= '0;
      to_cnt   <= '0;
      turn_r   <= O_FIRST;
      x_en_r   <= '0;
      o_en_r   <= '0;
      ack_r    <= 1'b0;
      nack_r   <= 1'b0;
      to_r     <= 1'b0;
      over_r   <= 1'b0;
      winner_r <= 2'b00;
    end else begin
      ack_r  <= 1'b0;
      nack_r <= 1'b0;
      to_r   <= 1'b0;
      if (bus.new_game) begin
        // in-flight moves and same-cycle requests are silently dropped
        state    <= S_WAIT;
        board    <= '0;
        idx_r    <= '0;
        to_cnt   <= '0;
        turn_r   <= O_FIRST;
        x_en_r   <= '0;
        o_en_r   <= '0;
        over_r   <= 1'b0;
        winner_r <= 2'b00;
      end else begin
        case (state)
          S_WAIT: begin
            if (bus.move_valid) begin
              // a request on the terminal count beats the timeout
              to_cnt <= '0;
              if (bus.move_idx <= 4'd8) begin
                state <= S_CHECK;
                idx_r <= bus.move_idx;
                if (turn_r) o_en_r <= idx_oh;
                else        x_en_r <= idx_oh;
              end else begin
                nack_r <= 1'b1;
              end
            end else if (to_cnt == TO_LAST) begin
              to_r   <= 1'b1;
              turn_r <= ~turn_r;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            x_en_r <= '0;
            o_en_r <= '0;
            to_cnt <= '0;
            if (bus.illegal_move) begin
              nack_r <= 1'b1;
              state  <= S_WAIT;
            end else begin
              board[idx_r] <= mover;
              ack_r        <= 1'b1;
              state        <= S_EVAL;
            end
          end
          S_EVAL: begin
            to_cnt <= '0;
            if (|line_win) begin
              state    <= S_DONE;
              over_r   <= 1'b1;
              winner_r <= mover;
            end else if (board_full) begin
              state    <= S_DONE;
              over_r   <= 1'b1;
              winner_r <= DRAW;
            end else begin
              turn_r <= ~turn_r;
              state  <= S_WAIT;
            end
          end
          S_DONE: to_cnt <= '0;
          default: state <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.move_ready = (state == S_WAIT);
  assign bus.X_en       = x_en_r;
  assign bus.O_en       = o_en_r;
  assign bus.turn       = turn_r;
  assign bus.move_ack   = ack_r;
  assign bus.move_nack  = nack_r;
  assign bus.timeout    = to_r;
  assign bus.game_over  = over_r;
  assign bus.winner     = winner_r;
  assign bus.pos1       = board[0];
  assign bus.pos2       = board[1];
  assign bus.pos3       = board[2];
  assign bus.pos4       = board[3];
  assign bus.pos5       = board[4];
  assign bus.pos6       = board[5];
  assign bus.pos7       = board[6];
  assign bus.pos8       = board[7];
  assign bus.pos9       = board[8];
endmodule

// File: tb/tb_tictactoe_move_ctrl.sv
// Directed plus randomized game play against a square-array reference of the
// rules; the bench also plays the move checker (illegal = occupied square).
module tb_tictactoe_move_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tictactoe_move_ctrl_if bus();

  tictactoe_move_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5), .O_FIRST(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_board [9];
  int m_turn;
  bit m_over;
  int m_winner;
  int wait_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] dut_pos(input int k);
    case (k)
      0: return bus.pos1;
      1: return bus.pos2;
      2: return bus.pos3;
      3: return bus.pos4;
      4: return bus.pos5;
      5: return bus.pos6;
      6: return bus.pos7;
      7: return bus.pos8;
      default: return bus.pos9;
    endcase
  endfunction

  function automatic bit wins(input int mark);
    bit w = 0;
    for (int r = 0; r < 3; r++) begin
      if (m_board[3*r] == mark && m_board[3*r+1] == mark && m_board[3*r+2] == mark) w = 1;
      if (m_board[r] == mark && m_board[r+3] == mark && m_board[r+6] == mark) w = 1;
    end
    if (m_board[0] == mark && m_board[4] == mark && m_board[8] == mark) w = 1;
    if (m_board[2] == mark && m_board[4] == mark && m_board[6] == mark) w = 1;
    return w;
  endfunction

  function automatic bit full();
    for (int k = 0; k < 9; k++) if (m_board[k] == 0) return 0;
    return 1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 9; k++) m_board[k] = 0;
    m_turn = 0; m_over = 0; m_winner = 0; wait_cnt = 0;
  endtask

  task automatic check_board(input string tag);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_pos%0d", tag, k + 1), {30'd0, dut_pos(k)}, m_board[k]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (m_over) begin
        chk("idle_to_done", bus.timeout, 0);
      end else begin
        wait_cnt++;
        if (wait_cnt == TO) begin
          chk("idle_timeout", bus.timeout, 1);
          m_turn ^= 1;
          wait_cnt = 0;
        end else begin
          chk("idle_no_timeout", bus.timeout, 0);
        end
      end
      chk("idle_turn", bus.turn, m_turn);
      chk("idle_ready", bus.move_ready, !m_over);
    end
  endtask

  task automatic new_game_t(input bit with_hs);
    bus.new_game = 1'b1;
    bus.move_valid = with_hs;
    bus.move_idx = 4'd4;
    step();
    bus.new_game = 1'b0;
    bus.move_valid = 1'b0;
    model_clear();
    chk("ng_ready", bus.move_ready, 1);
    chk("ng_turn", bus.turn, 0);
    chk("ng_over", bus.game_over, 0);
    chk("ng_winner", bus.winner, 0);
    chk("ng_ack", bus.move_ack, 0);
    chk("ng_nack", bus.move_nack, 0);
    chk("ng_en", {bus.X_en, bus.O_en}, 0);
    check_board("ng");
  endtask

  task automatic do_move(input int idx);
    logic [8:0] oh;
    int mark;
    bit illegal;
    chk("ready_pre", bus.move_ready, !m_over);
    bus.move_valid = 1'b1;
    bus.move_idx = idx[3:0];
    step();
    bus.move_valid = 1'b0;
    if (m_over) begin
      chk("done_ack", bus.move_ack, 0);
      chk("done_nack", bus.move_nack, 0);
      chk("done_en", {bus.X_en, bus.O_en}, 0);
      chk("done_ready", bus.move_ready, 0);
      chk("done_over", bus.game_over, 1);
      chk("done_winner", bus.winner, m_winner);
      check_board("done");
      return;
    end
    wait_cnt = 0;
    chk("to_on_hs", bus.timeout, 0);
    if (idx > 8) begin
      chk("bad_nack", bus.move_nack, 1);
      chk("bad_ack", bus.move_ack, 0);
      chk("bad_en", {bus.X_en, bus.O_en}, 0);
      chk("bad_ready", bus.move_ready, 1);
      return;
    end
    oh = 9'b1 << idx;
    chk("t1_X_en", bus.X_en, m_turn ? 9'd0 : oh);
    chk("t1_O_en", bus.O_en, m_turn ? oh : 9'd0);
    chk("t1_ready", bus.move_ready, 0);
    illegal = (m_board[idx] != 0);
    bus.illegal_move = illegal;
    step();
    bus.illegal_move = 1'b0;
    chk("t2_en", {bus.X_en, bus.O_en}, 0);
    if (illegal) begin
      chk("t2_nack", bus.move_nack, 1);
      chk("t2_ack_ill", bus.move_ack, 0);
      chk("t2_ready_ill", bus.move_ready, 1);
      chk("t2_turn_ill", bus.turn, m_turn);
      check_board("ill");
      return;
    end
    mark = m_turn ? 2 : 1;
    m_board[idx] = mark;
    chk("t2_ack", bus.move_ack, 1);
    chk("t2_nack_legal", bus.move_nack, 0);
    chk("t2_ready", bus.move_ready, 0);
    check_board("t2");
    step();
    if (wins(mark)) begin
      m_over = 1; m_winner = mark;
    end else if (full()) begin
      m_over = 1; m_winner = 3;
    end else begin
      m_turn ^= 1;
    end
    chk("t3_ack", bus.move_ack, 0);
    chk("t3_turn", bus.turn, m_turn);
    chk("t3_over", bus.game_over, m_over);
    chk("t3_winner", bus.winner, m_over ? m_winner : 0);
    chk("t3_ready", bus.move_ready, !m_over);
  endtask

  initial begin
    int seq_win [5];
    int seq_draw [9];
    int idx;
    seq_win  = '{0, 3, 1, 4, 2};
    seq_draw = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    bus.new_game = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_idx = 4'd0;
    bus.illegal_move = 1'b0;
    model_clear();

    #2;
    chk("rst_ready", bus.move_ready, 1);
    chk("rst_en", {bus.X_en, bus.O_en}, 0);
    chk("rst_pulses", {bus.move_ack, bus.move_nack, bus.timeout}, 0);
    chk("rst_over", bus.game_over, 0);
    chk("rst_winner", bus.winner, 0);
    chk("rst_turn", bus.turn, 0);
    check_board("rst");
    #10 rst_n = 1'b1;

    do_move(4);
    do_move(4);
    do_move(9);

    // async reset while the enable is driven
    bus.move_valid = 1'b1;
    bus.move_idx = 4'd2;
    step();
    bus.move_valid = 1'b0;
    chk("arst_pre_O_en", bus.O_en, 9'h004);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst_en", {bus.X_en, bus.O_en}, 0);
    chk("arst_ready", bus.move_ready, 1);
    chk("arst_turn", bus.turn, 0);
    check_board("arst");
    rst_n = 1'b1;

    new_game_t(1'b1);
    foreach (seq_win[i]) do_move(seq_win[i]);
    chk("win_winner", bus.winner, 2'b01);
    do_move(6);
    idle(3);

    new_game_t(1'b0);
    foreach (seq_draw[i]) do_move(seq_draw[i]);
    chk("draw_winner", bus.winner, 2'b11);
    new_game_t(1'b0);

    // new_game while a move is in S_CHECK
    bus.move_valid = 1'b1;
    bus.move_idx = 4'd0;
    step();
    bus.move_valid = 1'b0;
    chk("mid_X_en", bus.X_en, 9'h001);
    new_game_t(1'b0);

    idle(TO);
    chk("to_turn_after", bus.turn, 1);
    idle(TO - 1);
    do_move(0);

    for (int g = 0; g < 6; g++) begin
      new_game_t(1'($urandom_range(0, 1)));
      for (int n = 0; n < 40 && !m_over; n++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 20)));
        if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(9, 15));
        else                           idx = int'($urandom_range(0, 8));
        do_move(idx);
      end
      do_move(int'($urandom_range(0, 8)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
